fft_frame_sequencer: RTL and testbench

- Sequences one N-point FFT frame through the shared complex RAM.
- Load phase: accepts a stream of complex samples and writes them in pairs through the I/O port of the RAM arbiter.
- Compute phase: pulses fft_start and holds fft_busy, which gives the FFT engine the RAM until fft_done.
- Unload phase: reads the results back in pairs and streams them out over a valid/ready interface.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_out_buffer.sv | 45 ++++
 rtl/fft_frame_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and sizing for the FFT frame sequencer and its output buffer.
package fft_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        KICK    = 2'd1,
        COMPUTE = 2'd2,
        UNLOAD  = 2'd3
    } state_t;

    localparam int DEF_N         = 32;
    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_SAMPLE_W  = 2 * DEF_WORD_SIZE;

    function automatic int sample_width(input int word_size);
        return 2 * word_size;
    endfunction

endpackage

// File: rtl/fft_out_buffer.sv
// Two-entry skid buffer: loads a read pair at once, pops one sample per out handshake.
// Output is registered; o_sample holds while stalled. Parent loads only when o_empty.
module fft_out_buffer
    import fft_pkg::*;
#(
    parameter int W = DEF_SAMPLE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_sample1,
    input  logic [W-1:0] i_sample2,
    output logic         o_empty,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_sample
);

    logic [1:0]   r_cnt;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         w_pop;

    assign w_pop = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else if (i_load) begin
            r_cnt  <= 2'd2;
            r_head <= i_sample1;
            r_tail <= i_sample2;
        end else if (w_pop) begin
            r_cnt  <= r_cnt - 2'd1;
            r_head <= r_tail;
        end
    end

    assign o_valid  = (r_cnt != 2'd0);
    assign o_empty  = ~o_valid;
    assign o_sample = r_head;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Loads one N-point frame into the shared RAM in pairs, hands the RAM to the FFT engine,
// then streams results out in natural order; input stalls outside LOAD, output obeys out_ready.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int N             = DEF_N,
    parameter int word_size     = DEF_WORD_SIZE,
    parameter int address_width = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*word_size-1:0]   in_sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*word_size-1:0]   out_sample,
    output logic                     fft_start,
    input  logic                     fft_done,
    output logic                     fft_busy,
    output logic                     io_wr_en,
    output logic [address_width-1:0] io_wr_address1,
    output logic [address_width-1:0] io_wr_address2,
    output logic [2*word_size-1:0]   io_wr_sample1,
    output logic [2*word_size-1:0]   io_wr_sample2,
    output logic [address_width-1:0] io_rd_address1,
    output logic [address_width-1:0] io_rd_address2,
    input  logic [2*word_size-1:0]   io_rd_sample1,
    input  logic [2*word_size-1:0]   io_rd_sample2,
    output logic [15:0]              frame_count
);

    localparam int AW = address_width;
    localparam int SW = sample_width(word_size);
    localparam logic [AW:0] C_LAST = (AW+1)'(N - 1);
    localparam logic [AW:0] C_END  = (AW+1)'(N);
    localparam logic [AW:0] C_ONE  = (AW+1)'(1);
    localparam logic [AW:0] C_TWO  = (AW+1)'(2);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW:0]   r_load_idx;
    logic [AW:0]   r_rd_idx;
    logic [AW:0]   r_out_idx;
    logic [SW-1:0] r_hold;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_a1;
    logic [AW-1:0] r_wr_a2;
    logic [SW-1:0] r_wr_s1;
    logic [SW-1:0] r_wr_s2;
    logic [AW-1:0] r_rd_a1;
    logic [AW-1:0] r_rd_a2;
    logic          r_rd_issue;
    logic          r_rd_dvld;
    logic          r_fft_start;
    logic          r_fft_busy;
    logic [15:0]   r_frame_cnt;

    logic w_in_ready;
    logic w_in_hs;
    logic w_out_hs;
    logic w_load_last;
    logic w_out_last;
    logic w_rd_go;
    logic w_start_nxt;
    logic w_busy_nxt;
    logic w_buf_empty;
    logic w_buf_vld;

    assign w_in_hs     = in_valid & w_in_ready;
    assign w_out_hs    = w_buf_vld & out_ready;
    assign w_load_last = (r_load_idx == C_LAST);
    assign w_out_last  = (r_out_idx == C_LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= LOAD;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    if (w_in_hs && w_load_last) w_state_nxt = KICK;
            KICK:    w_state_nxt = COMPUTE;
            COMPUTE: if (fft_done) w_state_nxt = UNLOAD;
            UNLOAD:  if (w_out_hs && w_out_last) w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    // One read pair in flight at most, and only into an empty buffer, so loads never meet pops.
    always_comb begin
        w_in_ready  = (r_state == LOAD);
        w_start_nxt = (r_state == KICK);
        w_busy_nxt  = (r_state == KICK) || ((r_state == COMPUTE) && !fft_done);
        w_rd_go     = (r_state == UNLOAD) && w_buf_empty && !r_rd_issue && !r_rd_dvld
                      && (r_rd_idx != C_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_idx  <= '0;
            r_rd_idx    <= '0;
            r_out_idx   <= '0;
            r_hold      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_a1     <= '0;
            r_wr_a2     <= '0;
            r_wr_s1     <= '0;
            r_wr_s2     <= '0;
            r_rd_a1     <= '0;
            r_rd_a2     <= '0;
            r_rd_issue  <= 1'b0;
            r_rd_dvld   <= 1'b0;
            r_fft_start <= 1'b0;
            r_fft_busy  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_wr_en     <= 1'b0;
            r_fft_start <= w_start_nxt;
            r_fft_busy  <= w_busy_nxt;
            r_rd_issue  <= w_rd_go;
            r_rd_dvld   <= r_rd_issue;
            if (w_in_hs) begin
                r_load_idx <= w_load_last ? '0 : r_load_idx + C_ONE;
                if (!r_load_idx[0]) begin
                    r_hold <= in_sample;
                end else begin
                    r_wr_en <= 1'b1;
                    r_wr_a1 <= {r_load_idx[AW-1:1], 1'b0};
                    r_wr_a2 <= r_load_idx[AW-1:0];
                    r_wr_s1 <= r_hold;
                    r_wr_s2 <= in_sample;
                end
            end
            if (w_rd_go) begin
                r_rd_a1  <= {r_rd_idx[AW-1:1], 1'b0};
                r_rd_a2  <= {r_rd_idx[AW-1:1], 1'b1};
                r_rd_idx <= r_rd_idx + C_TWO;
            end
            if (w_out_hs) begin
                if (w_out_last) begin
                    r_out_idx   <= '0;
                    r_rd_idx    <= '0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_out_idx <= r_out_idx + C_ONE;
                end
            end
        end
    end

    fft_out_buffer #(.W(SW)) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .i_load    (r_rd_dvld),
        .i_sample1 (io_rd_sample1),
        .i_sample2 (io_rd_sample2),
        .o_empty   (w_buf_empty),
        .o_valid   (w_buf_vld),
        .i_ready   (out_ready),
        .o_sample  (out_sample)
    );

    assign in_ready       = w_in_ready;
    assign out_valid      = w_buf_vld;
    assign fft_start      = r_fft_start;
    assign fft_busy       = r_fft_busy;
    assign io_wr_en       = r_wr_en;
    assign io_wr_address1 = r_wr_a1;
    assign io_wr_address2 = r_wr_a2;
    assign io_wr_sample1  = r_wr_s1;
    assign io_wr_sample2  = r_wr_s2;
    assign io_rd_address1 = r_rd_a1;
    assign io_rd_address2 = r_rd_a2;
    assign frame_count    = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench: acts as the shared RAM and FFT engine; scoreboards writes and output samples.
module tb_fft_frame_sequencer;

    localparam int N  = 32;
    localparam int WS = 16;
    localparam int AW = 5;
    localparam int SW = 2 * WS;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sample;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sample;
    logic          fft_start;
    logic          fft_done;
    logic          fft_busy;
    logic          io_wr_en;
    logic [AW-1:0] io_wr_address1;
    logic [AW-1:0] io_wr_address2;
    logic [SW-1:0] io_wr_sample1;
    logic [SW-1:0] io_wr_sample2;
    logic [AW-1:0] io_rd_address1;
    logic [AW-1:0] io_rd_address2;
    logic [SW-1:0] io_rd_sample1;
    logic [SW-1:0] io_rd_sample2;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    fft_frame_sequencer #(.N(N), .word_size(WS), .address_width(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sample      (in_sample),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sample     (out_sample),
        .fft_start      (fft_start),
        .fft_done       (fft_done),
        .fft_busy       (fft_busy),
        .io_wr_en       (io_wr_en),
        .io_wr_address1 (io_wr_address1),
        .io_wr_address2 (io_wr_address2),
        .io_wr_sample1  (io_wr_sample1),
        .io_wr_sample2  (io_wr_sample2),
        .io_rd_address1 (io_rd_address1),
        .io_rd_address2 (io_rd_address2),
        .io_rd_sample1  (io_rd_sample1),
        .io_rd_sample2  (io_rd_sample2),
        .frame_count    (frame_count)
    );

    typedef struct packed {
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [SW-1:0] s1;
        logic [SW-1:0] s2;
    } wr_t;

    wr_t           exp_wr[$];
    logic [SW-1:0] exp_out[$];
    logic [SW-1:0] ram[N];
    logic [SW-1:0] loaded[N];
    int            checks = 0;
    int            errors = 0;
    int            n_start = 0;
    int            exp_frames = 0;
    bit            rnd_ready = 1'b0;
    bit            eng_apply = 1'b0;
    int            eng_mode = 0;
    logic [SW-1:0] eng_key = '0;

    // Engine result: mode 0 overwrites address a with value a, otherwise XORs a key.
    function automatic logic [SW-1:0] eng_f(input logic [SW-1:0] x, input int a,
                                            input int mode, input logic [SW-1:0] key);
        if (mode == 0) return SW'(a);
        return x ^ key;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(posedge clk) begin
        if (eng_apply) begin
            for (int a = 0; a < N; a++) ram[a] <= eng_f(ram[a], a, eng_mode, eng_key);
        end else if (io_wr_en && !fft_busy) begin
            ram[io_wr_address1] <= io_wr_sample1;
            ram[io_wr_address2] <= io_wr_sample2;
        end
        io_rd_sample1 <= ram[io_rd_address1];
        io_rd_sample2 <= ram[io_rd_address2];
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Write monitor and start-pulse counter.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (fft_start) n_start++;
                if (io_wr_en) begin
                    chk("write_while_busy", fft_busy, 0);
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", {io_wr_address1, io_wr_address2}, 64'hFFFF);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("write_addr", {io_wr_address1, io_wr_address2}, {e.a1, e.a2});
                        chk("write_data", {io_wr_sample1, io_wr_sample2}, {e.s1, e.s2});
                    end
                end
            end
        end
    end

    // Output monitor: scoreboard pop on handshake, stability while stalled.
    initial begin
        bit            stall;
        logic [SW-1:0] held;
        logic [SW-1:0] e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) chk("out_stable", {out_valid, out_sample}, {1'b1, held});
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        chk("unexpected_output", out_sample, 64'hDEAD_0000_0000);
                    end else begin
                        e = exp_out.pop_front();
                        chk("out_sample", out_sample, e);
                    end
                end
                stall = out_valid && !out_ready;
                held  = out_sample;
            end
        end
    end

    task automatic do_reset;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        fft_done = 1'b0;
        exp_wr.delete();
        exp_out.delete();
        exp_frames = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_strobes", {out_valid, fft_start, fft_busy, io_wr_en}, 0);
        chk("rst_addr", {io_wr_address1, io_wr_address2, io_rd_address1, io_rd_address2}, 0);
        chk("rst_wr_data", {io_wr_sample1, io_wr_sample2}, 0);
        chk("rst_out_sample", out_sample, 0);
        chk("rst_frame_count", frame_count, 0);
    endtask

    task automatic load_samples(input int n, input bit ramp);
        logic [SW-1:0] s;
        wr_t           w;
        int            t;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            s = ramp ? {16'(i), 16'(-i)} : SW'($urandom);
            in_sample = s;
            in_valid  = 1'b1;
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) chk("in_ready_timeout", in_ready, 1);
            @(posedge clk);
            #1;
            loaded[i] = s;
            if (i % 2 == 1) begin
                w.a1 = AW'(i - 1);
                w.a2 = AW'(i);
                w.s1 = loaded[i-1];
                w.s2 = s;
                exp_wr.push_back(w);
            end
        end
        in_valid = 1'b0;
    endtask

    // Called right after the handshake of the last sample of a frame.
    task automatic finish_frame(input int mode, input logic [SW-1:0] key,
                                input int delay, input bit rr);
        int t;
        @(negedge clk);
        chk("kick_in_ready", in_ready, 0);
        chk("last_write_timing", {io_wr_en, fft_busy, fft_start}, 3'b100);
        @(negedge clk);
        chk("start_pulse", {fft_start, fft_busy, io_wr_en}, 3'b110);
        for (int a = 0; a < N; a++) exp_out.push_back(eng_f(loaded[a], a, mode, key));
        eng_mode  = mode;
        eng_key   = key;
        rnd_ready = rr;
        for (int c = 0; c < delay; c++) begin
            @(negedge clk);
            eng_apply = (c == 0);
            chk("compute_hold", {fft_busy, fft_start, in_ready, io_wr_en, out_valid}, 5'b10000);
        end
        eng_apply = 1'b0;
        fft_done  = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        chk("busy_fall", fft_busy, 0);
        chk("frame_count_hold", frame_count, 16'(exp_frames));
        t = 0;
        while (exp_out.size() != 0 && t < N * 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("unload_done", exp_out.size(), 0);
        chk("frame_count_before_last", frame_count, 16'(exp_frames));
        exp_frames++;
        @(negedge clk);
        chk("frame_count", frame_count, 16'(exp_frames));
        chk("in_ready_after_unload", in_ready, 1);
        chk("write_queue_drained", exp_wr.size(), 0);
        rnd_ready = 1'b0;
    endtask

    initial begin
        int st0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        fft_done  = 1'b0;
        do_reset();

        load_samples(N, 1'b1);
        finish_frame(0, '0, 100, 1'b0);
        chk("one_start", n_start, 1);

        load_samples(N, 1'b0);
        finish_frame(1, SW'($urandom), 5 + int'($urandom_range(0, 20)), 1'b1);

        load_samples(13, 1'b0);
        do_reset();
        load_samples(N, 1'b0);
        finish_frame(1, SW'($urandom), 7, 1'b1);

        do_reset();
        st0 = n_start;
        @(posedge clk);
        #1;
        fft_done = 1'b1;
        @(posedge clk);
        #1;
        fft_done = 1'b0;
        @(negedge clk);
        chk("spurious_done", {fft_busy, fft_start, in_ready}, 3'b001);
        load_samples(N, 1'b0);
        finish_frame(1, SW'($urandom), 3, 1'b1);
        load_samples(N, 1'b1);
        finish_frame(0, '0, 4, 1'b0);
        chk("two_starts", n_start - st0, 2);
        chk("frame_count_two", frame_count, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
